rom_read_ctrl: RTL and testbench

Clocked initiator for the dirom-family asynchronous ROM macro, shown here for the 32768x8 instance. It accepts single or burst read requests from a synchronous host. It generates the ROM pin sequence (NRST, AD setup, CS strobe, EN output enable) with programmable cycle-count timing. It captures DO and returns bytes to the host with a valid pulse, and sits between the CPU/bus fabric and the ROM hard macro.

---
 rtl/rom_ctrl_pkg.sv | 28 ++
 rtl/rom_ctrl_timer.sv | 21 ++
 rtl/rom_read_ctrl.sv | 89 ++++++++
 tb/tb_rom_read_ctrl.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_ctrl_pkg.sv
// rom_ctrl_pkg: shared widths, FSM states and phase timing for the ROM read controller
package rom_ctrl_pkg;

    localparam int ROM_AW = 15;
    localparam int ROM_DW = 8;
    localparam int LEN_W  = 4;
    localparam int CNT_W  = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        STROBE  = 3'd2,
        HOLDOFF = 3'd3,
        CAPTURE = 3'd4,
        RECOV   = 3'd5
    } state_t;

    // Number of cycles spent in a state; IDLE and CAPTURE are single-cycle phases.
    function automatic logic [CNT_W-1:0] phase_len(input state_t s, input int ad_setup,
                                                   input int cs_high, input int access,
                                                   input int cs_low);
        return CNT_W'(s == SETUP   ? ad_setup :
                      s == STROBE  ? cs_high :
                      s == HOLDOFF ? access - cs_high :
                      s == RECOV   ? cs_low : 1);
    endfunction

endpackage

// File: rtl/rom_ctrl_timer.sv
// rom_ctrl_timer: loadable down-counter pacing each FSM phase
module rom_ctrl_timer import rom_ctrl_pkg::*; (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    logic [CNT_W-1:0] cnt;

    // reload on state entry, otherwise count down and park at zero
    always_ff @(posedge clk or posedge rst)
        if (rst)
            cnt <= '0;
        else
            cnt <= load ? load_val : (cnt != '0 ? cnt - CNT_W'(1) : cnt);

    assign done = cnt == '0;

endmodule

// File: rtl/rom_read_ctrl.sv
// rom_read_ctrl: clocked initiator sequencing dirom NRST/AD/CS/EN for single and burst reads
module rom_read_ctrl import rom_ctrl_pkg::*; #(
    parameter int AD_SETUP_CYC = 1,
    parameter int CS_HIGH_CYC  = 2,
    parameter int ACCESS_CYC   = 3,
    parameter int CS_LOW_CYC   = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              REQ_VALID,
    output logic              REQ_READY,
    input  logic [ROM_AW-1:0] REQ_ADDR,
    input  logic [LEN_W-1:0]  REQ_LEN,
    output logic              RVALID,
    output logic [ROM_DW-1:0] RDATA,
    output logic              RLAST,
    output logic              BUSY,
    output logic              ROM_NRST,
    output logic              ROM_CS,
    output logic              ROM_EN,
    output logic [ROM_AW-1:0] ROM_AD,
    input  logic [ROM_DW-1:0] ROM_DO
);

    if (AD_SETUP_CYC < 1 || CS_HIGH_CYC < 1 || ACCESS_CYC < CS_HIGH_CYC || CS_LOW_CYC < 1) begin : g_bad_timing
        $error("rom_read_ctrl: invalid timing parameters");
    end

    state_t           state, state_nxt;
    logic [LEN_W-1:0] remaining;
    logic [CNT_W-1:0] load_val;
    logic             accept, phase_done, last_byte;

    assign accept    = REQ_VALID & REQ_READY;
    assign last_byte = remaining == '0;
    assign BUSY      = state != IDLE;
    assign load_val  = phase_len(state_nxt, AD_SETUP_CYC, CS_HIGH_CYC, ACCESS_CYC, CS_LOW_CYC) - CNT_W'(1);

    rom_ctrl_timer u_timer (
        .clk      (CLK),
        .rst      (RST),
        .load     (state_nxt != state),
        .load_val (load_val),
        .done     (phase_done)
    );

    // advance when the phase timer expires; HOLDOFF vanishes when access equals the strobe width
    always_comb
        state_nxt = state == IDLE    ? (accept ? SETUP : IDLE) :
                    !phase_done      ? state :
                    state == SETUP   ? STROBE :
                    state == STROBE  ? (ACCESS_CYC > CS_HIGH_CYC ? HOLDOFF : CAPTURE) :
                    state == HOLDOFF ? CAPTURE :
                    state == CAPTURE ? RECOV :
                    last_byte        ? IDLE : SETUP;

    // pins and handshake are registered from the upcoming state so they change with it
    always_ff @(posedge CLK or posedge RST)
        if (RST) begin
            state     <= IDLE;
            remaining <= '0;
            ROM_NRST  <= 1'b0;
            ROM_CS    <= 1'b0;
            ROM_EN    <= 1'b1;
            ROM_AD    <= '0;
            REQ_READY <= 1'b0;
            RVALID    <= 1'b0;
            RLAST     <= 1'b0;
            RDATA     <= '0;
        end else begin
            state     <= state_nxt;
            ROM_NRST  <= 1'b1;
            REQ_READY <= ROM_NRST && state == IDLE && state_nxt == IDLE;
            ROM_CS    <= state_nxt == STROBE;
            ROM_EN    <= !(state_nxt inside {STROBE, HOLDOFF, CAPTURE});
            RVALID    <= state == CAPTURE;
            RLAST     <= state == CAPTURE && last_byte;
            if (state == CAPTURE)
                RDATA <= ROM_DO;
            if (accept) begin
                ROM_AD    <= REQ_ADDR;
                remaining <= REQ_LEN;
            end else if (state == RECOV && state_nxt == SETUP) begin
                ROM_AD    <= ROM_AD + ROM_AW'(1);
                remaining <= remaining - LEN_W'(1);
            end
        end

endmodule

// File: tb/tb_rom_read_ctrl.sv
// tb_rom_read_ctrl: scoreboard bench for rom_read_ctrl at default and stretched timing
module tb_rom_read_ctrl;
    import rom_ctrl_pkg::*;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    logic [7:0] mem [0:32767];

    logic        req_valid = 1'b0;
    logic [14:0] req_addr = '0;
    logic [3:0]  req_len = '0;
    logic        req_ready, rvalid, rlast, busy, rom_nrst, rom_cs, rom_en;
    logic [7:0]  rdata, rom_do;
    logic [7:0]  a_lat = '0;
    logic [14:0] rom_ad;

    logic        b_req_valid = 1'b0;
    logic [14:0] b_req_addr = '0;
    logic [3:0]  b_req_len = '0;
    logic        b_req_ready, b_rvalid, b_rlast, b_busy, b_rom_nrst, b_rom_cs, b_rom_en;
    logic [7:0]  b_rdata, b_rom_do;
    logic [7:0]  b_lat = '0;
    logic [14:0] b_rom_ad;

    rom_read_ctrl dut_a (
        .CLK(CLK), .RST(RST), .REQ_VALID(req_valid), .REQ_READY(req_ready),
        .REQ_ADDR(req_addr), .REQ_LEN(req_len), .RVALID(rvalid), .RDATA(rdata),
        .RLAST(rlast), .BUSY(busy), .ROM_NRST(rom_nrst), .ROM_CS(rom_cs),
        .ROM_EN(rom_en), .ROM_AD(rom_ad), .ROM_DO(rom_do)
    );

    rom_read_ctrl #(.AD_SETUP_CYC(3), .CS_HIGH_CYC(1), .ACCESS_CYC(4), .CS_LOW_CYC(2)) dut_b (
        .CLK(CLK), .RST(RST), .REQ_VALID(b_req_valid), .REQ_READY(b_req_ready),
        .REQ_ADDR(b_req_addr), .REQ_LEN(b_req_len), .RVALID(b_rvalid), .RDATA(b_rdata),
        .RLAST(b_rlast), .BUSY(b_busy), .ROM_NRST(b_rom_nrst), .ROM_CS(b_rom_cs),
        .ROM_EN(b_rom_en), .ROM_AD(b_rom_ad), .ROM_DO(b_rom_do)
    );

    // ROM models: word latched on CS rise, driven only while EN is low (0xEE stands for Z)
    always @(posedge rom_cs) a_lat <= mem[rom_ad];
    always @(posedge b_rom_cs) b_lat <= mem[b_rom_ad];
    assign rom_do   = rom_en ? 8'hEE : a_lat;
    assign b_rom_do = b_rom_en ? 8'hEE : b_lat;

    logic [8:0]  a_exp[$], b_exp[$];
    int          a_rv[$], b_rv[$], b_cs[$];
    logic [14:0] a_cs_ad[$];

    task automatic tick();
        @(negedge CLK);
        #1;
    endtask

    task automatic mon_a();
        logic [14:0] prev_ad = '0;
        logic        prev_cs = 1'b0;
        int          age = 0;
        logic [8:0]  e;
        forever begin
            @(negedge CLK);
            checks++;
            if ((rom_ad != prev_ad && (rom_cs || !rom_en)) || (rom_cs && !rom_nrst) || (!busy && !rom_en)) begin
                errors++;
                $display("FAIL a_pin_rules: cyc %0d ad=%h prev=%h cs=%b en=%b nrst=%b busy=%b, required ad stable while strobed, no cs in reset, en=1 when idle",
                         cyc, rom_ad, prev_ad, rom_cs, rom_en, rom_nrst, busy);
            end
            if (rom_ad != prev_ad) age = 0;
            if (rom_cs && !prev_cs) begin
                a_cs_ad.push_back(rom_ad);
                checks++;
                if (age < 1) begin
                    errors++;
                    $display("FAIL a_ad_setup: cyc %0d setup %0d cycles, required >= 1", cyc, age);
                end
            end
            if (rvalid) begin
                a_rv.push_back(cyc);
                checks++;
                if (a_exp.size() == 0) begin
                    errors++;
                    $display("FAIL a_unexpected_rvalid: cyc %0d data %h, required no pulse", cyc, rdata);
                end else begin
                    e = a_exp.pop_front();
                    if ({rlast, rdata} !== e) begin
                        errors++;
                        $display("FAIL a_read_data: cyc %0d last/data %b/%h, required %b/%h", cyc, rlast, rdata, e[8], e[7:0]);
                    end
                end
            end
            age++;
            prev_ad = rom_ad;
            prev_cs = rom_cs;
        end
    endtask

    task automatic mon_b();
        logic [14:0] prev_ad = '0;
        logic        prev_cs = 1'b0;
        int          age = 0;
        logic [8:0]  e;
        forever begin
            @(negedge CLK);
            checks++;
            if ((b_rom_ad != prev_ad && (b_rom_cs || !b_rom_en)) || (b_rom_cs && !b_rom_nrst) || (!b_busy && !b_rom_en)) begin
                errors++;
                $display("FAIL b_pin_rules: cyc %0d ad=%h prev=%h cs=%b en=%b nrst=%b busy=%b, required ad stable while strobed, no cs in reset, en=1 when idle",
                         cyc, b_rom_ad, prev_ad, b_rom_cs, b_rom_en, b_rom_nrst, b_busy);
            end
            if (b_rom_ad != prev_ad) age = 0;
            if (b_rom_cs && !prev_cs) begin
                b_cs.push_back(cyc);
                checks++;
                if (age < 3) begin
                    errors++;
                    $display("FAIL b_ad_setup: cyc %0d setup %0d cycles, required >= 3", cyc, age);
                end
            end
            if (b_rvalid) begin
                b_rv.push_back(cyc);
                checks++;
                if (b_exp.size() == 0) begin
                    errors++;
                    $display("FAIL b_unexpected_rvalid: cyc %0d data %h, required no pulse", cyc, b_rdata);
                end else begin
                    e = b_exp.pop_front();
                    if ({b_rlast, b_rdata} !== e) begin
                        errors++;
                        $display("FAIL b_read_data: cyc %0d last/data %b/%h, required %b/%h", cyc, b_rlast, b_rdata, e[8], e[7:0]);
                    end
                end
            end
            age++;
            prev_ad = b_rom_ad;
            prev_cs = b_rom_cs;
        end
    endtask

    // drives a request on the default instance, queues its bytes, returns the accept cycle
    task automatic send_a(input logic [14:0] addr, input logic [3:0] len, output int acc);
        int t = 0;
        req_valid = 1'b1;
        req_addr  = addr;
        req_len   = len;
        while (!req_ready && t < 200) begin
            tick();
            t++;
        end
        checks++;
        if (!req_ready) begin
            errors++;
            $display("FAIL a_ready_timeout: req_ready %b after %0d cycles, required 1", req_ready, t);
        end
        for (int i = 0; i <= int'(len); i++)
            a_exp.push_back({i == int'(len), mem[addr + 15'(i)]});
        tick();
        acc = cyc;
        req_valid = 1'b0;
    endtask

    task automatic wait_a(input int limit);
        for (int i = 0; i < limit && (a_exp.size() != 0 || !req_ready); i++) tick();
    endtask

    task automatic test_reset();
        tick();
        checks++;
        if ({rom_nrst, rom_cs, rom_en, rom_ad, req_ready, rvalid, rlast, rdata, busy} !==
            {1'b0, 1'b0, 1'b1, 15'h0000, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0}) begin
            errors++;
            $display("FAIL reset_values_a: nrst/cs/en=%b%b%b ad=%h rdy=%b rv=%b rl=%b rd=%h busy=%b, required 001 0000 0 0 0 00 0",
                     rom_nrst, rom_cs, rom_en, rom_ad, req_ready, rvalid, rlast, rdata, busy);
        end
        checks++;
        if ({b_rom_nrst, b_rom_cs, b_rom_en, b_req_ready, b_busy} !== 5'b00100) begin
            errors++;
            $display("FAIL reset_values_b: nrst/cs/en/rdy/busy=%b%b%b%b%b, required 00100", b_rom_nrst, b_rom_cs, b_rom_en, b_req_ready, b_busy);
        end
        RST = 1'b0;
        tick();
        checks++;
        if ({rom_nrst, req_ready, rom_cs} !== 3'b100) begin
            errors++;
            $display("FAIL reset_release_edge1: nrst/rdy/cs=%b%b%b, required 100", rom_nrst, req_ready, rom_cs);
        end
        tick();
        checks++;
        if ({rom_nrst, req_ready, rom_cs, b_req_ready} !== 4'b1101) begin
            errors++;
            $display("FAIL reset_release_edge2: nrst/rdy/cs/b_rdy=%b%b%b%b, required 1101", rom_nrst, req_ready, rom_cs, b_req_ready);
        end
    endtask

    task automatic test_single();
        int acc;
        logic [3:0] pins [8];
        pins = '{4'b0100, 4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b0110, 4'b0100, 4'b0101};
        send_a(15'h0010, 4'd0, acc);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if ({rom_cs, rom_en, rvalid, req_ready} !== pins[i]) begin
                errors++;
                $display("FAIL single_pins: accept+%0d cs/en/rv/rdy=%b, required %b", i, {rom_cs, rom_en, rvalid, req_ready}, pins[i]);
            end
            if (i < 6) begin
                checks++;
                if (rom_ad !== 15'h0010) begin
                    errors++;
                    $display("FAIL single_addr: accept+%0d ad=%h, required 0010", i, rom_ad);
                end
            end
            if (i == 5) begin
                checks++;
                if ({rlast, rdata} !== 9'h1A5) begin
                    errors++;
                    $display("FAIL single_data: last/data %b/%h, required 1/a5", rlast, rdata);
                end
            end
            if (i < 7) tick();
        end
        wait_a(20);
    endtask

    task automatic test_burst_wrap();
        int acc;
        logic [14:0] ads [4];
        ads = '{15'h7FFE, 15'h7FFF, 15'h0000, 15'h0001};
        a_rv.delete();
        a_cs_ad.delete();
        send_a(15'h7FFE, 4'd3, acc);
        wait_a(100);
        checks++;
        if (a_exp.size() != 0 || a_rv.size() != 4 || a_cs_ad.size() != 4) begin
            errors++;
            $display("FAIL burst_count: pending %0d pulses %0d strobes %0d, required 0 4 4", a_exp.size(), a_rv.size(), a_cs_ad.size());
        end
        for (int i = 0; i < a_cs_ad.size() && i < 4; i++) begin
            checks++;
            if (a_cs_ad[i] !== ads[i]) begin
                errors++;
                $display("FAIL burst_addr: byte %0d ad=%h, required %h", i, a_cs_ad[i], ads[i]);
            end
        end
        for (int i = 1; i < a_rv.size(); i++) begin
            checks++;
            if (a_rv[i] - a_rv[i-1] != 6) begin
                errors++;
                $display("FAIL burst_period: byte %0d period %0d, required 6", i, a_rv[i] - a_rv[i-1]);
            end
        end
        if (a_rv.size() > 0) begin
            checks++;
            if (a_rv[0] - acc != 5) begin
                errors++;
                $display("FAIL burst_latency: %0d cycles, required 5", a_rv[0] - acc);
            end
        end
    endtask

    task automatic test_timing_params();
        int acc;
        int t = 0;
        b_rv.delete();
        b_cs.delete();
        b_req_valid = 1'b1;
        b_req_addr  = 15'h1234;
        b_req_len   = 4'd2;
        while (!b_req_ready && t < 50) begin
            tick();
            t++;
        end
        for (int i = 0; i < 3; i++)
            b_exp.push_back({i == 2, mem[15'h1234 + 15'(i)]});
        tick();
        acc = cyc;
        b_req_valid = 1'b0;
        for (t = 0; t < 200 && (b_exp.size() != 0 || !b_req_ready); t++) tick();
        checks++;
        if (b_exp.size() != 0 || b_rv.size() != 3 || b_cs.size() != 3) begin
            errors++;
            $display("FAIL timing_count: pending %0d pulses %0d strobes %0d, required 0 3 3", b_exp.size(), b_rv.size(), b_cs.size());
        end
        if (b_rv.size() > 0 && b_cs.size() > 0) begin
            checks++;
            if (b_rv[0] - acc != 8 || b_cs[0] - acc != 3) begin
                errors++;
                $display("FAIL timing_latency: rvalid +%0d cs +%0d, required +8 +3", b_rv[0] - acc, b_cs[0] - acc);
            end
        end
        for (int i = 1; i < b_rv.size() && i < b_cs.size(); i++) begin
            checks++;
            if (b_rv[i] - b_rv[i-1] != 10 || b_cs[i] - b_cs[i-1] != 10) begin
                errors++;
                $display("FAIL timing_period: byte %0d rvalid %0d cs %0d, required 10 10", i, b_rv[i] - b_rv[i-1], b_cs[i] - b_cs[i-1]);
            end
        end
    endtask

    task automatic test_reset_midburst();
        int acc;
        int t = 0;
        a_rv.delete();
        send_a(15'h0200, 4'd3, acc);
        while (a_rv.size() < 1 && t < 50) begin
            tick();
            t++;
        end
        while (!rom_cs && t < 60) begin
            tick();
            t++;
        end
        checks++;
        if (!rom_cs || a_rv.size() != 1) begin
            errors++;
            $display("FAIL midburst_reach: cs %b pulses %0d, required 1 1", rom_cs, a_rv.size());
        end
        RST = 1'b1;
        #1;
        checks++;
        if ({rom_cs, rom_en, rom_nrst, rvalid, busy, req_ready} !== 6'b010000) begin
            errors++;
            $display("FAIL midburst_async: cs/en/nrst/rv/busy/rdy=%b%b%b%b%b%b, required 010000", rom_cs, rom_en, rom_nrst, rvalid, busy, req_ready);
        end
        a_exp.delete();
        tick();
        tick();
        RST = 1'b0;
        repeat (20) tick();
        checks++;
        if (a_rv.size() != 1) begin
            errors++;
            $display("FAIL midburst_discard: pulses %0d, required 1", a_rv.size());
        end
        send_a(15'h0ABC, 4'd0, acc);
        wait_a(50);
        checks++;
        if (a_exp.size() != 0 || a_rv.size() != 2) begin
            errors++;
            $display("FAIL midburst_recover: pending %0d pulses %0d, required 0 2", a_exp.size(), a_rv.size());
        end
    endtask

    task automatic test_held_request();
        int acc;
        int t = 0;
        a_cs_ad.delete();
        send_a(15'h0300, 4'd1, acc);
        req_valid = 1'b1;
        req_addr  = 15'h0555;
        req_len   = 4'd0;
        while (!req_ready && t < 100) begin
            tick();
            t++;
        end
        checks++;
        if (cyc - acc != 13) begin
            errors++;
            $display("FAIL held_ready_delay: ready after %0d cycles, required 13", cyc - acc);
        end
        checks++;
        if (a_cs_ad.size() != 2 || a_cs_ad[0] !== 15'h0300 || a_cs_ad[1] !== 15'h0301) begin
            errors++;
            $display("FAIL held_ignored: strobes %0d first %h second %h, required 2 0300 0301", a_cs_ad.size(), a_cs_ad[0], a_cs_ad[1]);
        end
        a_exp.push_back({1'b1, mem[15'h0555]});
        tick();
        req_valid = 1'b0;
        checks++;
        if (rom_ad !== 15'h0555 || !busy || req_ready) begin
            errors++;
            $display("FAIL held_accept: ad=%h busy=%b rdy=%b, required 0555 1 0", rom_ad, busy, req_ready);
        end
        wait_a(50);
        checks++;
        if (a_exp.size() != 0) begin
            errors++;
            $display("FAIL held_drain: pending %0d, required 0", a_exp.size());
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation still running at %0t, required completion", $time);
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 32768; i++) mem[i] = 8'(i * 37 + (i >> 9));
        mem[16] = 8'hA5;
        fork
            mon_a();
            mon_b();
        join_none
        test_reset();
        test_single();
        test_burst_wrap();
        test_timing_params();
        test_reset_midburst();
        test_held_request();
        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
